// File: rtl/byte_encode.sv
// byte_encode: Kyber ByteEncode_l packer.
// Takes 256 l-bit coefficients, packed MSB-first several per 64-bit word.
// Emits the 32*l-byte little-endian bit stream as 4*l 64-bit words,
// with lane 0 (bits 63:56) holding the earliest byte.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A source holds its data stable while valid && !ready. Valid
// never waits for ready. Here the input ready (o_coeffs_ready) and the
// output valid (o_obytes_valid) are never high together, so an accept and
// a pop cannot happen in the same cycle.
module byte_encode (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_coeffs,
    input  logic        i_coeffs_valid,
    output logic        o_coeffs_ready,
    input  logic [3:0]  i_l,
    output logic [63:0] o_obytes,
    output logic        o_obytes_valid,
    input  logic        i_obytes_ready,
    output logic        o_done,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int NUM_L = 6;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_l;
    logic [3:0]     w_l_nxt;
    logic [6:0]     r_fill;
    logic [6:0]     w_fill_nxt;
    logic [8:0]     r_count;
    logic [8:0]     w_count_nxt;
    logic [127:0]   r_acc;
    logic [127:0]   w_acc_nxt;
    logic           r_valid;
    logic           w_valid_nxt;
    logic [63:0]    r_obytes;
    logic [63:0]    w_obytes_nxt;

    logic [3:0]     w_l_cur;
    logic [63:0]    w_chunk;
    logic [6:0]     w_n;
    logic           w_legal;
    logic [8:0]     w_rem;
    logic [6:0]     w_take;
    logic [6:0]     w_bits;
    logic [63:0]    w_mask;
    logic [127:0]   w_ins;
    logic           w_coeffs_ready;

    // The width in force is the live input while idle and the latched one
    // for the rest of the frame, so late changes of i_l are ignored.
    assign w_l_cur = (r_state == S_IDLE) ? i_l : r_l;

    // For every legal width, rearrange the MSB-first coefficient fields into
    // LSB-first stream order: bit k of coefficient j lands at j*L+k.
    for (genvar g = 0; g < NUM_L; g++) begin : g_pack
        localparam int L = (g == 0) ? 1 :
                           (g == 1) ? 4 :
                           (g == 2) ? 5 :
                           (g == 3) ? 10 :
                           (g == 4) ? 11 : 12;
        localparam int N = 64 / L;
        logic [63:0] w_p;
        for (genvar j = 0; j < N; j++) begin : g_coef
            for (genvar k = 0; k < L; k++) begin : g_bit
                assign w_p[j*L + k] = i_coeffs[64 - (j+1)*L + k];
            end
        end
        if (N*L < 64) begin : g_pad
            assign w_p[63:N*L] = '0;
        end
    end

    // Select the stream-ordered chunk and coefficients-per-word for the current width.
    always_comb begin
        w_chunk = '0;
        w_n     = '0;
        case (w_l_cur)
            4'd1:    begin w_chunk = g_pack[0].w_p; w_n = 7'd64; end
            4'd4:    begin w_chunk = g_pack[1].w_p; w_n = 7'd16; end
            4'd5:    begin w_chunk = g_pack[2].w_p; w_n = 7'd12; end
            4'd10:   begin w_chunk = g_pack[3].w_p; w_n = 7'd6;  end
            4'd11:   begin w_chunk = g_pack[4].w_p; w_n = 7'd5;  end
            4'd12:   begin w_chunk = g_pack[5].w_p; w_n = 7'd5;  end
            default: begin w_chunk = '0;            w_n = 7'd0;  end
        endcase
    end

    assign w_legal = (w_n != 7'd0);

    // The last word of a frame may carry more coefficients than are still
    // needed; only the first (256 - count) are taken, the rest are dropped.
    assign w_rem  = 9'd256 - r_count;
    assign w_take = (w_rem < {2'b00, w_n}) ? w_rem[6:0] : w_n;
    assign w_bits = 7'(w_take * {3'b000, w_l_cur});
    assign w_mask = (w_bits == 7'd64) ? {64{1'b1}} : ((64'd1 << w_bits) - 64'd1);
    assign w_ins  = {64'b0, w_chunk & w_mask} << r_fill;

    // Lane m of the output carries accumulator byte m.
    function automatic logic [63:0] f_lanes(input logic [63:0] a);
        return {a[7:0],   a[15:8],  a[23:16], a[31:24],
                a[39:32], a[47:40], a[55:48], a[63:56]};
    endfunction

    // Next-state, accept/pop bookkeeping and next output register values.
    always_comb begin
        w_state_nxt    = r_state;
        w_l_nxt        = r_l;
        w_fill_nxt     = r_fill;
        w_count_nxt    = r_count;
        w_acc_nxt      = r_acc;
        w_coeffs_ready = 1'b0;
        w_valid_nxt    = 1'b0;
        w_obytes_nxt   = '0;

        case (r_state)
            S_IDLE:  w_coeffs_ready = w_legal;
            S_RUN:   w_coeffs_ready = (r_fill < 7'd64) && (r_count < 9'd256);
            default: w_coeffs_ready = 1'b0;
        endcase

        if (w_coeffs_ready && i_coeffs_valid) begin
            // Append the taken bits directly above the current fill.
            w_state_nxt = S_RUN;
            w_l_nxt     = w_l_cur;
            w_fill_nxt  = r_fill + w_bits;
            w_count_nxt = r_count + {2'b00, w_take};
            w_acc_nxt   = r_acc | w_ins;
        end else if ((r_state == S_RUN) && r_valid && i_obytes_ready) begin
            // Oldest 64 bits leave; 256*l is a multiple of 64, so the frame
            // ends exactly when the last coefficient's bits are popped.
            w_acc_nxt  = {64'b0, r_acc[127:64]};
            w_fill_nxt = r_fill - 7'd64;
            if ((r_count == 9'd256) && (r_fill == 7'd64)) begin
                w_state_nxt = S_DONE;
            end
        end else if (r_state == S_DONE) begin
            w_state_nxt = S_IDLE;
            w_fill_nxt  = '0;
            w_count_nxt = '0;
            w_acc_nxt   = '0;
        end

        w_valid_nxt  = (w_state_nxt == S_RUN) && (w_fill_nxt >= 7'd64);
        w_obytes_nxt = w_valid_nxt ? f_lanes(w_acc_nxt[63:0]) : 64'd0;
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_l      <= '0;
            r_fill   <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_valid  <= 1'b0;
            r_obytes <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_l      <= w_l_nxt;
            r_fill   <= w_fill_nxt;
            r_count  <= w_count_nxt;
            r_acc    <= w_acc_nxt;
            r_valid  <= w_valid_nxt;
            r_obytes <= w_obytes_nxt;
        end
    end

    assign o_coeffs_ready = w_coeffs_ready & ~i_rst;
    assign o_obytes       = r_obytes;
    assign o_obytes_valid = r_valid;
    assign o_done         = (r_state == S_DONE);
    assign o_dbg_state    = r_state;

endmodule
